// File: rtl/uart_tx_sb_ctrl.sv
// uart_tx_sb_ctrl
// Bus-mapped UART transmitter: 8 data bits LSB first, optional even parity,
// one or two stop bits. A small register file sits on the system bus; the
// serialiser FSM drives a registered tx_o so the line never sees decode glitches.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, waiting for a data write
// ST_START  | start bit (low) for baud_div cycles
// ST_DATA   | 8 data bits from shift_q[0], baud_div cycles each
// ST_PARITY | even parity bit of the byte, baud_div cycles
// ST_STOP   | stop bit(s) high, baud_div cycles each, one or two bits

module uart_tx_sb_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'd87
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        tx_o
);

  localparam logic [23:0] OFF_DATA   = 24'h00_0000;
  localparam logic [23:0] OFF_BUSY   = 24'h00_0004;
  localparam logic [23:0] OFF_DIV    = 24'h00_0008;
  localparam logic [23:0] OFF_PARITY = 24'h00_000C;
  localparam logic [23:0] OFF_STOP   = 24'h00_0010;
  localparam logic [23:0] OFF_RST    = 24'h00_0024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;

  logic [15:0] baud_div_q;
  logic        parity_en_q;
  logic        stopbit_q;

  logic        ready_q;
  logic [31:0] read_data_q, read_data_d;

  logic [23:0] off;
  logic        wr, rd, idle;
  logic        data_wr_ok, div_wr_ok, par_wr_ok, stop_wr_ok, soft_rst;
  logic        baud_tc;

  // Upper address byte is always zero and data bits above 15 carry nothing.
  logic        unused_bits;
  assign unused_bits = ^{addr_i[31:24], write_data_i[31:16]};

  assign off  = addr_i[23:0];
  assign wr   = req_i & write_enable_i;
  assign rd   = req_i & ~write_enable_i;
  assign idle = (state_q == ST_IDLE);

  // Config is only writable while idle, so the live registers stay frozen for
  // the whole frame and serve as the frame's latched settings.
  assign data_wr_ok = wr && (off == OFF_DATA) && idle;
  assign div_wr_ok  = wr && (off == OFF_DIV) && idle && (write_data_i[15:1] != 15'd0);
  assign par_wr_ok  = wr && (off == OFF_PARITY) && idle;
  assign stop_wr_ok = wr && (off == OFF_STOP) && idle;
  assign soft_rst   = wr && (off == OFF_RST) && write_data_i[0];

  assign baud_tc = (baud_cnt_q == (baud_div_q - 16'd1));

  // Configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_div_q  <= DEFAULT_DIV;
      parity_en_q <= 1'b0;
      stopbit_q   <= 1'b0;
    end else if (soft_rst) begin
      baud_div_q  <= DEFAULT_DIV;
      parity_en_q <= 1'b0;
      stopbit_q   <= 1'b0;
    end else begin
      if (div_wr_ok)  baud_div_q  <= write_data_i[15:0];
      if (par_wr_ok)  parity_en_q <= write_data_i[0];
      if (stop_wr_ok) stopbit_q   <= write_data_i[0];
    end
  end

  // Read data mux; unmapped and write-only offsets read as zero.
  always_comb begin
    read_data_d = 32'd0;
    case (off)
      OFF_BUSY:   read_data_d = {31'd0, ~idle};
      OFF_DIV:    read_data_d = {16'd0, baud_div_q};
      OFF_PARITY: read_data_d = {31'd0, parity_en_q};
      OFF_STOP:   read_data_d = {31'd0, stopbit_q};
      default:    read_data_d = 32'd0;
    endcase
  end

  // Bus response: ready follows every request by one cycle, including the
  // soft-reset write itself so the requester never stalls waiting for it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q     <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      ready_q <= req_i;
      if (soft_rst)
        read_data_q <= 32'd0;
      else if (rd)
        read_data_q <= read_data_d;
    end
  end

  // Serialiser next-state logic; tx_d is derived from the next state so the
  // line register changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = 1'b1;

    if (state_q != ST_IDLE) begin
      if (baud_tc)
        baud_cnt_d = 16'd0;
      else
        baud_cnt_d = baud_cnt_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (data_wr_ok) begin
          shift_d    = write_data_i[7:0];
          par_d      = ^write_data_i[7:0];
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_tc) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = parity_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tc) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tc) begin
          if (stopbit_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Serialiser state and line register; soft reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else if (soft_rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o        = tx_q;
  assign ready_o     = ready_q;
  assign read_data_o = read_data_q;

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Directed bench for uart_tx_sb_ctrl: bus register access, frame shapes,
// config lock while busy, hard/soft reset and back-to-back frames.
`timescale 1ns/1ps
module tb_uart_tx_sb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] cap_vec;
  int           cap_n = 0;
  int           cap_req = 0;
  int           cap_seen = 0;

  logic [255:0] exp_vec;
  int           exp_len;

  uart_tx_sb_ctrl #(.DEFAULT_DIV(16'd87)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .write_enable_i (we),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
    .ready_o        (ready),
    .tx_o           (tx)
  );

  always #5 clk = ~clk;

  // Line capture, one sample per cycle on the falling edge, restarted on request.
  always @(negedge clk) begin
    if (cap_req != cap_seen) begin
      cap_seen = cap_req;
      cap_n    = 0;
      cap_vec  = '1;
    end
    if (cap_n < 256) begin
      cap_vec[cap_n] = tx;
      cap_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    check("wr_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, input string tag, input logic [31:0] expv);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check(tag, rdata, expv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_write(32'h00, {24'd0, b});
    cap_req++;
  endtask

  task automatic exp_clear();
    exp_vec = '1;
    exp_len = 0;
  endtask

  task automatic exp_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_vec[exp_len] = v;
      exp_len++;
    end
  endtask

  task automatic exp_frame(input logic [7:0] b, input int d, input bit p, input bit s);
    exp_bits(1'b0, d);
    for (int i = 0; i < 8; i++) exp_bits(b[i], d);
    if (p) exp_bits(^b, d);
    exp_bits(1'b1, s ? 2 * d : d);
  endtask

  task automatic check_cap(input string tag);
    logic [255:0] mask;
    mask = '0;
    for (int i = 0; i < exp_len; i++) mask[i] = 1'b1;
    n_tests++;
    assert (cap_n >= exp_len && (cap_vec & mask) === (exp_vec & mask)) else begin
      n_fail++;
      $error("FAIL %s: observed %h (%0d samples) expected %h (%0d samples)",
             tag, cap_vec & mask, cap_n, exp_vec & mask, exp_len);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    bus_read(32'h04, "rst_busy", 32'd0);
    bus_read(32'h08, "rst_div", 32'd87);
    bus_read(32'h0C, "rst_par", 32'd0);
    bus_read(32'h10, "rst_stop", 32'd0);
    @(posedge clk); #1;
    check("ready_drop", {31'd0, ready}, 32'd0);

    // Plain 8N1 frame, with ignored writes while busy
    bus_write(32'h08, 32'd4);
    bus_read(32'h08, "div4", 32'd4);
    send_byte(8'hA5);
    bus_read(32'h04, "busy_during", 32'd1);
    bus_write(32'h00, 32'h3C);
    bus_write(32'h08, 32'd10);
    repeat (50) @(posedge clk);
    #1;
    exp_clear(); exp_frame(8'hA5, 4, 1'b0, 1'b0); exp_bits(1'b1, 8);
    check_cap("frame_a5_8n1");
    check("frame_a5_last_data", {31'd0, cap_vec[35]}, 32'd1);
    bus_read(32'h04, "busy_after", 32'd0);
    bus_read(32'h08, "div_locked", 32'd4);

    // Illegal divisors, unmapped read, read data hold across writes
    bus_write(32'h08, 32'd1);
    bus_read(32'h08, "div_wr1", 32'd4);
    bus_write(32'h08, 32'd0);
    bus_read(32'h08, "div_wr0", 32'd4);
    bus_read(32'h40, "unmapped", 32'd0);
    bus_read(32'h08, "div_again", 32'd4);
    bus_write(32'h40, 32'hFFFF_FFFF);
    check("rdata_hold", rdata, 32'd4);

    // 8E2 frames
    bus_write(32'h0C, 32'd1);
    bus_write(32'h10, 32'd1);
    bus_read(32'h0C, "par_rb", 32'd1);
    bus_read(32'h10, "stop_rb", 32'd1);
    send_byte(8'hA5);
    repeat (60) @(posedge clk);
    #1;
    exp_clear(); exp_frame(8'hA5, 4, 1'b1, 1'b1); exp_bits(1'b1, 8);
    check_cap("frame_a5_8e2");
    check("parity_a5", {31'd0, cap_vec[36]}, 32'd0);
    send_byte(8'h07);
    repeat (60) @(posedge clk);
    #1;
    exp_clear(); exp_frame(8'h07, 4, 1'b1, 1'b1); exp_bits(1'b1, 8);
    check_cap("frame_07_8e2");
    check("parity_07", {31'd0, cap_vec[39]}, 32'd1);

    // Hard reset mid-DATA
    send_byte(8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(32'h04, "hrst_busy", 32'd0);
    bus_read(32'h08, "hrst_div", 32'd87);
    bus_read(32'h0C, "hrst_par", 32'd0);
    bus_read(32'h10, "hrst_stop", 32'd0);

    // Soft reset mid-DATA
    bus_write(32'h08, 32'd4);
    bus_write(32'h10, 32'd1);
    send_byte(8'h00);
    repeat (8) @(posedge clk);
    #1;
    check("pre_srst_tx", {31'd0, tx}, 32'd0);
    bus_write(32'h24, 32'd1);
    check("srst_tx", {31'd0, tx}, 32'd1);
    bus_read(32'h04, "srst_busy", 32'd0);
    bus_read(32'h08, "srst_div", 32'd87);
    bus_read(32'h10, "srst_stop", 32'd0);

    // Back-to-back frames: second write lands on the first idle cycle
    bus_write(32'h08, 32'd4);
    send_byte(8'hA5);
    repeat (40) @(posedge clk);
    bus_write(32'h00, 32'h55);
    repeat (50) @(posedge clk);
    #1;
    exp_clear();
    exp_frame(8'hA5, 4, 1'b0, 1'b0);
    exp_bits(1'b1, 1);
    exp_frame(8'h55, 4, 1'b0, 1'b0);
    exp_bits(1'b1, 6);
    check_cap("back_to_back");
    check("b2b_second_start", {31'd0, cap_vec[41]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
